// File: rtl/adder_operand_packer_pkg.sv
// Shared types and constants for the adder operand packer and the 3-input adder bench.
package adder_operand_packer_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_C    = 2'd2,
    S_FULL = 2'd3
  } state_t;

  localparam int ADDER_LATENCY = 2;
  localparam int WIDTH_DEF     = 8;
  localparam int CNT_W_DEF     = 16;

  // Number of words already held in the current triple for a given state.
  function automatic logic [1:0] fill_of(input state_t s);
    logic [1:0] f;
    case (s)
      S_A:     f = 2'd0;
      S_B:     f = 2'd1;
      S_C:     f = 2'd2;
      S_FULL:  f = 2'd3;
      default: f = 2'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/adder_operand_packer_if.sv
// Word stream in, operand triple and issue/sum-valid strobes out.
interface adder_operand_packer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_en;
  logic             i_flush;
  logic [WIDTH-1:0] o_a;
  logic [WIDTH-1:0] o_b;
  logic [WIDTH-1:0] o_c;
  logic             o_issue;
  logic             o_sum_valid;
  logic [1:0]       o_fill;
  logic [CNT_W-1:0] o_triple_count;

  modport master (
    output i_data, i_valid, i_en, i_flush,
    input  o_ready, o_a, o_b, o_c, o_issue, o_sum_valid, o_fill, o_triple_count
  );

  modport slave (
    input  i_data, i_valid, i_en, i_flush,
    output o_ready, o_a, o_b, o_c, o_issue, o_sum_valid, o_fill, o_triple_count
  );

endinterface

// File: rtl/adder_operand_packer_valid_delay_line.sv
// Fixed-depth 1-bit shift register; cleared by reset so in-flight strobes are dropped.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vld,
  output logic o_vld
);

  logic [DEPTH-1:0] vld_p;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= i_vld;
      for (int k = 1; k < DEPTH; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  assign o_vld = vld_p[DEPTH-1];

endmodule

// File: rtl/adder_operand_packer.sv
// Collects a valid/ready word stream into (a,b,c) triples for the 3-input pipelined adder
// and tracks when each issued triple's sum emerges from the adder.
module adder_operand_packer #(
  parameter int WIDTH         = 8,
  parameter int ADDER_LATENCY = adder_operand_packer_pkg::ADDER_LATENCY,
  parameter int CNT_W         = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  adder_operand_packer_if.slave  bus
);

  import adder_operand_packer_pkg::*;

  state_t           state_q;
  state_t           state_d;
  logic             ready;
  logic             accept;
  logic             issue;
  logic             wr_a;
  logic             wr_b;
  logic             wr_c;
  logic             sum_valid;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = S_A;
    end else begin
      case (state_q)
        S_A:     if (accept) state_d = S_B;
        S_B:     if (accept) state_d = S_C;
        S_C:     if (accept) state_d = S_FULL;
        S_FULL:  if (issue)  state_d = accept ? S_B : S_A;
        default: state_d = S_A;
      endcase
    end
  end

  // In S_FULL, readiness follows i_en combinationally so a new word can land in
  // slot a on the very cycle the held triple is issued.
  always_comb begin
    ready  = 1'b0;
    issue  = 1'b0;
    accept = 1'b0;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    wr_c   = 1'b0;
    if (!bus.i_flush) begin
      ready = (state_q != S_FULL) || bus.i_en;
      issue = (state_q == S_FULL) && bus.i_en;
    end
    accept = bus.i_valid && ready;
    wr_a   = accept && ((state_q == S_A) || (state_q == S_FULL));
    wr_b   = accept && (state_q == S_B);
    wr_c   = accept && (state_q == S_C);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (wr_a) a_q <= bus.i_data;
      if (wr_b) b_q <= bus.i_data;
      if (wr_c) c_q <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  valid_delay_line #(
    .DEPTH (ADDER_LATENCY)
  ) u_sum_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_vld (issue),
    .o_vld (sum_valid)
  );

  assign bus.o_ready        = ready;
  assign bus.o_issue        = issue;
  assign bus.o_a            = a_q;
  assign bus.o_b            = b_q;
  assign bus.o_c            = c_q;
  assign bus.o_sum_valid    = sum_valid;
  assign bus.o_fill         = fill_of(state_q);
  assign bus.o_triple_count = cnt_q;

endmodule
